eq_band_controller: RTL and testbench
=====================================

// Module: eq_band_controller
// PURPOSE
// Keyboard-driven controller for the 12-band graphic equalizer. Holds the per-band gain
// setting, moves the band cursor, and issues gain updates to the audio coefficient loader
// over a valid/ready handshake. Publishes frame-synchronous dial values and cursor to the
// VGA equalizer display, so bars never tear mid-frame.
// PARAMETERS
// NUM_BANDS  12     number of bands; band 0 = 31 Hz ... band 11 = 20 kHz
// GAIN_W     5      gain code width
// GAIN_MAX   24     max code (+12 dB); code 0 = -12 dB, 1 dB/step
// GAIN_DEF   12     reset/flat code (0 dB)
// KEY_LEFT   8'h6B  cursor left scancode
// KEY_RIGHT  8'h74  cursor right scancode
// KEY_UP     8'h75  gain +1 scancode
// KEY_DOWN   8'h72  gain -1 scancode
// KEY_FLAT   8'h2B  flatten-all scancode (EQ_FLAT_CMD_EN only)
// PORTS
// clk50        in   1                 system clock, 50 MHz
// reset        in   1                 synchronous, active-high
// key_valid    in   1                 scancode present
// key_code     in   8                 make code; consumed when key_valid & key_ready
// key_ready    out  1                 controller can accept a key
// frame_start  in   1                 1-cycle pulse from display at field wrap
// dials        out  NUM_BANDS*GAIN_W  shadowed gains; band b at [b*GAIN_W +: GAIN_W]
// sel_band     out  4                 shadowed cursor, for highlight
// upd_valid    out  1                 gain update pending
// upd_ready    in   1                 loader accepts update
// upd_band     out  4                 band being updated
// upd_gain     out  GAIN_W            new gain code
// BEHAVIOUR
// - Reset: gain[0..NUM_BANDS-1]=GAIN_DEF, cursor=0, state=IDLE; dials all GAIN_DEF,
//   sel_band=0, upd_valid=0, upd_band=0, upd_gain=GAIN_DEF, key_ready=1 on the next cycle.
//   No updates are issued after reset (loader resets to flat as well).
// - Reset mid-transfer: upd_valid is 0 the cycle after reset asserts; pending update dropped.
// - FSM: IDLE, UPDATE, FLAT (FLAT only with macro). key_ready = (state==IDLE).
// - IDLE, key accepted:
//   LEFT : cursor = (cursor==0) ? NUM_BANDS-1 : cursor-1 (wraps); no update.
//   RIGHT: cursor = (cursor==NUM_BANDS-1) ? 0 : cursor+1 (wraps); no update.
//   UP   : if gain[cursor]<GAIN_MAX: gain+=1, load upd_band/upd_gain, go UPDATE.
//          At GAIN_MAX: saturates, no update, stay IDLE.
//   DOWN : same, decrement, saturating at 0.
//   other: consumed and ignored.
// - Latency: upd_valid rises the cycle after key acceptance. upd_band/upd_gain stay stable
//   while upd_valid=1. Transfer completes on upd_valid & upd_ready. Return to IDLE next
//   cycle. upd_ready high on the first valid cycle gives a 1-cycle pulse.
// - Shadow: on frame_start, dials<=gain[], sel_band<=cursor. They are otherwise held.
//   frame_start in the same cycle as a gain/cursor write captures the pre-write value.
//   The new value appears at the following frame_start.
// - Arithmetic: unsigned GAIN_W compare before inc/dec; no overflow/underflow possible.
// CONFIGURATION
// EQ_FLAT_CMD_EN defined: KEY_FLAT in IDLE enters FLAT. For b=0..NUM_BANDS-1 in order:
//   gain[b]=GAIN_DEF; upd_band=b, upd_gain=GAIN_DEF, upd_valid=1 until accepted.
//   Always exactly NUM_BANDS transfers, even if a band is already flat. Cursor is unchanged.
//   After the last transfer: IDLE; key_ready=0 throughout.
// EQ_FLAT_CMD_EN undefined: FLAT state absent; KEY_FLAT is an ignored key.
// TESTING
// 1 reset, 2 frames idle -> dials all 5'd12, sel_band=0, upd_valid never high
// 2 RIGHT x3, UP, upd_ready=1 -> one transfer band=3 gain=13; next frame dials[19:15]=13
// 3 UP x14 on band 0, upd_ready=1 -> 12 transfers (13..24); last 2 UP give none, gain=24
// 4 LEFT at cursor 0 -> sel_band=11 after frame_start; DOWN on band 11 -> band=11 gain=11
// 5 UP with upd_ready=0 for 10 cycles -> upd_valid held, band/gain stable, key_ready=0,
//   second key stalled; reset asserted mid-wait -> upd_valid=0, dials=12 after frame_start
// 6 (EQ_FLAT_CMD_EN) band 2=20, KEY_FLAT, upd_ready toggling -> 12 transfers band 0..11
//   gain 12; then key_ready=1, gain[2]=12

Source files
------------

// File: rtl/eq_band_controller.sv
// eq_band_controller: keyboard-driven controller for a 12-band graphic equalizer.
// Holds per-band gain codes and the band cursor. Gain changes go to the
// coefficient loader over a valid/ready handshake. Gains and cursor are
// shadowed to the display on frame_start.
// Optional feature macro: EQ_FLAT_CMD_EN. It enables the flatten-all key,
// which rewrites every band to the flat code and issues one update per band.
module eq_band_controller #(
    parameter int          NUM_BANDS = 12,
    parameter int          GAIN_W    = 5,
    parameter int          GAIN_MAX  = 24,
    parameter int          GAIN_DEF  = 12,
    parameter logic [7:0]  KEY_LEFT  = 8'h6B,
    parameter logic [7:0]  KEY_RIGHT = 8'h74,
    parameter logic [7:0]  KEY_UP    = 8'h75,
    parameter logic [7:0]  KEY_DOWN  = 8'h72,
    parameter logic [7:0]  KEY_FLAT  = 8'h2B
) (
    input  logic                          clk50,
    input  logic                          reset,
    input  logic                          key_valid,
    input  logic [7:0]                    key_code,
    output logic                          key_ready,
    input  logic                          frame_start,
    output logic [NUM_BANDS*GAIN_W-1:0]   dials,
    output logic [3:0]                    sel_band,
    output logic                          upd_valid,
    input  logic                          upd_ready,
    output logic [3:0]                    upd_band,
    output logic [GAIN_W-1:0]             upd_gain
);

    localparam logic [GAIN_W-1:0] G_MAX     = GAIN_W'(GAIN_MAX);
    localparam logic [GAIN_W-1:0] G_DEF     = GAIN_W'(GAIN_DEF);
    localparam logic [GAIN_W-1:0] G_MIN     = '0;
    localparam logic [3:0]        LAST_BAND = 4'(NUM_BANDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE
`ifdef EQ_FLAT_CMD_EN
        , ST_FLAT
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cursor_q, cursor_d;
    logic [GAIN_W-1:0]   gain_q [NUM_BANDS];
    logic [3:0]          upd_band_q, upd_band_d;
    logic [GAIN_W-1:0]   upd_gain_q, upd_gain_d;
    logic [NUM_BANDS*GAIN_W-1:0] dials_q;
    logic [3:0]          sel_q;

    // single gain write port driven by the FSM
    logic                wr_en;
    logic [3:0]          wr_idx;
    logic [GAIN_W-1:0]   wr_val;
    logic [GAIN_W-1:0]   gain_cur;

    // Saturating step helpers; callers compare first so these never wrap.
    function automatic logic [GAIN_W-1:0] gain_inc(input logic [GAIN_W-1:0] g);
        return (g < G_MAX) ? g + 1'b1 : g;
    endfunction

    function automatic logic [GAIN_W-1:0] gain_dec(input logic [GAIN_W-1:0] g);
        return (g > G_MIN) ? g - 1'b1 : g;
    endfunction

    assign gain_cur = gain_q[cursor_q];

    // Next-state, cursor movement, gain write and update payload selection
    always_comb begin
        state_d    = state_q;
        cursor_d   = cursor_q;
        upd_band_d = upd_band_q;
        upd_gain_d = upd_gain_q;
        wr_en      = 1'b0;
        wr_idx     = cursor_q;
        wr_val     = gain_cur;

        case (state_q)
            ST_IDLE: begin
                // key_ready is high in IDLE, so key_valid alone means accepted
                if (key_valid) begin
                    case (key_code)
                        KEY_LEFT: begin
                            cursor_d = (cursor_q == 4'd0) ? LAST_BAND : cursor_q - 4'd1;
                        end
                        KEY_RIGHT: begin
                            cursor_d = (cursor_q == LAST_BAND) ? 4'd0 : cursor_q + 4'd1;
                        end
                        KEY_UP: begin
                            if (gain_cur < G_MAX) begin
                                wr_en      = 1'b1;
                                wr_val     = gain_inc(gain_cur);
                                upd_band_d = cursor_q;
                                upd_gain_d = gain_inc(gain_cur);
                                state_d    = ST_UPDATE;
                            end
                        end
                        KEY_DOWN: begin
                            if (gain_cur > G_MIN) begin
                                wr_en      = 1'b1;
                                wr_val     = gain_dec(gain_cur);
                                upd_band_d = cursor_q;
                                upd_gain_d = gain_dec(gain_cur);
                                state_d    = ST_UPDATE;
                            end
                        end
`ifdef EQ_FLAT_CMD_EN
                        KEY_FLAT: begin
                            // band 0 is written and offered immediately
                            wr_en      = 1'b1;
                            wr_idx     = 4'd0;
                            wr_val     = G_DEF;
                            upd_band_d = 4'd0;
                            upd_gain_d = G_DEF;
                            state_d    = ST_FLAT;
                        end
`else
                        KEY_FLAT: begin
                            // flatten command not built in: consumed like any unknown key
                        end
`endif
                        default: begin
                        end
                    endcase
                end
            end

            ST_UPDATE: begin
                if (upd_ready) begin
                    state_d = ST_IDLE;
                end
            end

`ifdef EQ_FLAT_CMD_EN
            ST_FLAT: begin
                // upd_band_q doubles as the band walker for the flatten sweep
                if (upd_ready) begin
                    if (upd_band_q == LAST_BAND) begin
                        state_d = ST_IDLE;
                    end else begin
                        wr_en      = 1'b1;
                        wr_idx     = upd_band_q + 4'd1;
                        wr_val     = G_DEF;
                        upd_band_d = upd_band_q + 4'd1;
                        upd_gain_d = G_DEF;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state, cursor, gain table and update payload registers
    always_ff @(posedge clk50) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cursor_q   <= 4'd0;
            upd_band_q <= 4'd0;
            upd_gain_q <= G_DEF;
            for (int b = 0; b < NUM_BANDS; b++) begin
                gain_q[b] <= G_DEF;
            end
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            upd_band_q <= upd_band_d;
            upd_gain_q <= upd_gain_d;
            for (int b = 0; b < NUM_BANDS; b++) begin
                if (wr_en && (wr_idx == 4'(b))) begin
                    gain_q[b] <= wr_val;
                end
            end
        end
    end

    // Display shadow: sampled only at frame_start so bars never tear mid-frame;
    // a same-cycle write is seen at the following frame
    always_ff @(posedge clk50) begin
        if (reset) begin
            dials_q <= {NUM_BANDS{G_DEF}};
            sel_q   <= 4'd0;
        end else if (frame_start) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                dials_q[b*GAIN_W +: GAIN_W] <= gain_q[b];
            end
            sel_q <= cursor_q;
        end
    end

    assign key_ready = (state_q == ST_IDLE);
    assign upd_valid = (state_q != ST_IDLE);
    assign upd_band  = upd_band_q;
    assign upd_gain  = upd_gain_q;
    assign dials     = dials_q;
    assign sel_band  = sel_q;

endmodule

// File: tb/tb_eq_band_controller.sv
// tb_eq_band_controller: directed self-checking bench for eq_band_controller.
module tb_eq_band_controller;

    localparam logic [7:0] K_LEFT  = 8'h6B;
    localparam logic [7:0] K_RIGHT = 8'h74;
    localparam logic [7:0] K_UP    = 8'h75;
    localparam logic [7:0] K_DOWN  = 8'h72;
    localparam logic [7:0] K_FLAT  = 8'h2B;

    logic        clk50 = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = 8'h00;
    logic        key_ready;
    logic        frame_start = 1'b0;
    logic [59:0] dials;
    logic [3:0]  sel_band;
    logic        upd_valid;
    logic        upd_ready = 1'b0;
    logic [3:0]  upd_band;
    logic [4:0]  upd_gain;

    int checks = 0;
    int failures = 0;

    logic [3:0] xb[$];
    logic [4:0] xg[$];

    eq_band_controller dut (
        .clk50(clk50), .reset(reset),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .frame_start(frame_start), .dials(dials), .sel_band(sel_band),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_band(upd_band), .upd_gain(upd_gain)
    );

    always #10 clk50 = ~clk50;

    // record every completed transfer
    always @(posedge clk50) begin
        if (!reset && upd_valid && upd_ready) begin
            xb.push_back(upd_band);
            xg.push_back(upd_gain);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk50);
        #1;
    endtask

    task automatic send_key(input logic [7:0] code);
        bit done;
        done = 0;
        key_valid = 1'b1;
        key_code  = code;
        for (int i = 0; i < 100 && !done; i++) begin
            if (key_ready) done = 1;
            cyc();
        end
        key_valid = 1'b0;
        if (!done) check("key_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic frame();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    logic [59:0] all12;
    bit          seen;
    bit          ok;

    initial begin
        all12 = {12{5'd12}};

        // 1: reset state, two idle frames
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        cyc();
        check("rst_key_ready", key_ready, 1);
        check("rst_upd_valid", upd_valid, 0);
        check("rst_upd_band", upd_band, 0);
        check("rst_upd_gain", upd_gain, 12);
        check("rst_dials", dials, all12);
        check("rst_sel_band", sel_band, 0);
        seen = 0;
        for (int f = 0; f < 2; f++) begin
            frame();
            for (int i = 0; i < 5; i++) begin
                if (upd_valid) seen = 1;
                cyc();
            end
        end
        check("idle_no_upd", seen, 0);
        check("idle_dials", dials, all12);
        check("idle_sel", sel_band, 0);

        // 2: RIGHT x3, UP -> band 3 gain 13
        upd_ready = 1'b1;
        send_key(K_RIGHT);
        send_key(K_RIGHT);
        send_key(K_RIGHT);
        send_key(K_UP);
        check("t2_valid", upd_valid, 1);
        check("t2_band", upd_band, 3);
        check("t2_gain", upd_gain, 13);
        cyc();
        check("t2_pulse_done", upd_valid, 0);
        check("t2_ready_back", key_ready, 1);
        check("t2_xfers", xb.size(), 1);
        check("t2_dials_held", dials, all12);
        frame();
        check("t2_dial3", dials[19:15], 13);
        check("t2_sel", sel_band, 3);

        // 3: UP x14 on band 0 -> 12 transfers 13..24, then saturation
        send_key(K_LEFT);
        send_key(K_LEFT);
        send_key(K_LEFT);
        xb.delete();
        xg.delete();
        for (int i = 0; i < 14; i++) send_key(K_UP);
        idle(3);
        check("t3_xfers", xb.size(), 12);
        ok = (xb.size() == 12);
        for (int i = 0; i < xb.size(); i++) begin
            if (xb[i] !== 4'd0 || xg[i] !== 5'(13 + i)) ok = 0;
        end
        check("t3_seq", ok, 1);
        check("t3_sat_idle", upd_valid, 0);
        frame();
        check("t3_dial0", dials[4:0], 24);
        check("t3_dial3", dials[19:15], 13);
        check("t3_sel", sel_band, 0);

        // 4: LEFT wraps to 11, DOWN on band 11
        send_key(K_LEFT);
        check("t4_sel_held", sel_band, 0);
        frame();
        check("t4_sel_wrap", sel_band, 11);
        xb.delete();
        xg.delete();
        send_key(K_DOWN);
        check("t4_band", upd_band, 11);
        check("t4_gain", upd_gain, 11);
        idle(2);
        check("t4_xfers", xb.size(), 1);
        frame();
        check("t4_dial11", dials[59:55], 11);

        // 5: stalled loader, second key held off, reset mid-wait
        upd_ready = 1'b0;
        xb.delete();
        xg.delete();
        send_key(K_UP);
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                key_valid = 1'b1;
                key_code  = K_RIGHT;
            end
            if (upd_valid !== 1'b1 || upd_band !== 4'd11 || upd_gain !== 5'd12 || key_ready !== 1'b0) ok = 0;
            cyc();
        end
        check("t5_held_stable", ok, 1);
        check("t5_valid", upd_valid, 1);
        check("t5_key_stalled", key_ready, 0);
        frame();
        check("t5_sel_no_move", sel_band, 11);
        key_valid = 1'b0;
        reset = 1'b1;
        cyc();
        check("t5_rst_valid", upd_valid, 0);
        reset = 1'b0;
        upd_ready = 1'b1;
        idle(3);
        check("t5_no_xfer", xb.size(), 0);
        check("t5_ready", key_ready, 1);
        frame();
        check("t5_dials_flat", dials, all12);
        check("t5_sel0", sel_band, 0);

`ifdef EQ_FLAT_CMD_EN
        // 6: band 2 to 20, then flatten with a toggling loader
        send_key(K_RIGHT);
        send_key(K_RIGHT);
        for (int i = 0; i < 8; i++) send_key(K_UP);
        idle(2);
        frame();
        check("t6_dial2_pre", dials[14:10], 20);
        xb.delete();
        xg.delete();
        send_key(K_FLAT);
        ok = 1;
        for (int i = 0; i < 200 && xb.size() < 12; i++) begin
            upd_ready = i[0];
            if (key_ready !== 1'b0) ok = 0;
            cyc();
        end
        upd_ready = 1'b0;
        check("t6_busy", ok, 1);
        check("t6_xfers", xb.size(), 12);
        ok = (xb.size() == 12);
        for (int i = 0; i < xb.size(); i++) begin
            if (xb[i] !== 4'(i) || xg[i] !== 5'd12) ok = 0;
        end
        check("t6_seq", ok, 1);
        check("t6_ready", key_ready, 1);
        frame();
        check("t6_dials", dials, all12);
        check("t6_sel", sel_band, 2);
`else
        // flatten key ignored in default build
        xb.delete();
        xg.delete();
        send_key(K_FLAT);
        idle(3);
        check("t6_flat_ignored", xb.size(), 0);
        check("t6_ready", key_ready, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
